// File: rtl/mem_ctrl_pkg.sv
// ============================================================================
// Module : mem_ctrl_pkg
// Brief  : Shared RV32I load/store codes, FSM states and helpers for mem_ctrl
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_ctrl_pkg;

  localparam int BYTE_W = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MC_IDLE   = 2'd0,
    MC_IF_RD  = 2'd1,
    MC_MEM_RD = 2'd2,
    MC_MEM_WR = 2'd3
  } mc_state_e;

  // Number of byte cycles an access needs; unknown sizes behave as a word.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      F3_SB[1:0]:        return 3'd1;
      F3_SH[1:0]:        return 3'd2;
      F3_SW[1:0], 2'b11: return 3'd4;
      default:           return 3'd4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_ctrl_ext.sv
// ============================================================================
// Module : mem_ctrl_ext
// Brief  : funct3-driven sign/zero extension of an assembled load word
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_ctrl_ext
  import mem_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] word_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = word_i;
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){word_i[7]}}, word_i[7:0]};
      F3_LH:   data_o = {{(XLEN-16){word_i[15]}}, word_i[15:0]};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, word_i[7:0]};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, word_i[15:0]};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module : mem_ctrl
// Brief  : Byte-serial RAM port master arbitrating instruction fetch and data
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [XLEN-1:0]   if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [2:0]        mem_funct3,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic              mem_done,
  output logic [XLEN-1:0]   mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_dout,
  output logic              ram_wr,
  input  logic [BYTE_W-1:0] ram_din,
  output logic              stall_req_if,
  output logic              stall_req_mem
);

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   asm_q, asm_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [BYTE_W-1:0] ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [XLEN-1:0]   if_inst_q, if_inst_d;
  logic [XLEN-1:0]   mem_rdata_q, mem_rdata_d;

  logic [2:0]        w_n;
  logic [2:0]        w_edge;
  logic [1:0]        w_byte_sel;
  logic [XLEN-1:0]   w_asm;
  logic [XLEN-1:0]   w_ext;

  // w_edge is the index of the edge about to happen, counted from the grant.
  assign w_n        = (state_q == MC_IF_RD) ? 3'd4 : access_bytes(f3_q);
  assign w_edge     = cnt_q + 3'd1;
  assign w_byte_sel = 2'(w_edge - 3'd2);

  always_comb begin
    w_asm = asm_q;
    w_asm[w_byte_sel*BYTE_W +: BYTE_W] = ram_din;
  end

  mem_ctrl_ext #(.XLEN(XLEN)) u_ext (
    .funct3_i (f3_q),
    .word_i   (w_asm),
    .data_o   (w_ext)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      MC_IDLE: begin
        // Requesters drop req during their done cycle, so never grant then.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            state_d    = mem_we ? MC_MEM_WR : MC_MEM_RD;
            base_d     = mem_addr;
            f3_d       = mem_funct3;
            wdata_d    = mem_wdata;
            asm_d      = '0;
            cnt_d      = 3'd0;
            ram_addr_d = mem_addr;
            ram_wr_d   = mem_we;
            ram_dout_d = mem_wdata[BYTE_W-1:0];
          end else if (if_req && !if_flush) begin
            state_d    = MC_IF_RD;
            base_d     = if_addr;
            asm_d      = '0;
            cnt_d      = 3'd0;
            ram_addr_d = if_addr;
            ram_wr_d   = 1'b0;
          end
        end
      end

      MC_IF_RD, MC_MEM_RD: begin
        if (state_q == MC_IF_RD && if_flush) begin
          state_d = MC_IDLE;
        end else begin
          cnt_d = w_edge;
          if (w_edge < w_n) ram_addr_d = base_q + ADDR_W'(w_edge);
          if (w_edge >= 3'd2) asm_d = w_asm;
          if (w_edge == w_n + 3'd1) begin
            state_d = MC_IDLE;
            if (state_q == MC_IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = w_asm;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = w_ext;
            end
          end
        end
      end

      MC_MEM_WR: begin
        cnt_d = w_edge;
        if (w_edge < w_n) begin
          ram_addr_d = base_q + ADDR_W'(w_edge);
          ram_dout_d = wdata_q[w_edge[1:0]*BYTE_W +: BYTE_W];
          ram_wr_d   = 1'b1;
        end else begin
          ram_wr_d   = 1'b0;
          mem_done_d = 1'b1;
          state_d    = MC_IDLE;
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      cnt_q       <= 3'd0;
      base_q      <= '0;
      f3_q        <= 3'd0;
      wdata_q     <= '0;
      asm_q       <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_dout      = ram_dout_q;
  assign ram_wr        = ram_wr_q;
  assign if_done       = if_done_q;
  assign mem_done      = mem_done_q;
  assign if_inst       = if_inst_q;
  assign mem_rdata     = mem_rdata_q;
  assign stall_req_if  = if_req & ~if_done_q & ~if_flush;
  assign stall_req_mem = mem_req & ~mem_done_q;

endmodule

`default_nettype wire
